imem_boot_loader: RTL and testbench

//   Upstream feeder for the Risc16 core. Receives a byte-stream program image
//   (valid/ready), packs bytes into 16-bit instruction words and writes them

---
 rtl/imem_boot_loader.sv | 129 ++++++++++++
 tb/tb_imem_boot_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: unpacks a framed byte stream into 16-bit imem writes and
// holds the core in reset until the image checksum has been verified.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_COUNT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  cpu_run,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_RUN, S_ERR} state_t;

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            xor_q, xor_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  run_q, run_d;
    logic                  err_q, err_d;
    logic                  acc, is_sync, len_ok;
    logic [ADDR_WIDTH:0]   idx_inc;

    assign in_ready     = ~rst;
    assign acc          = in_valid & in_ready;
    assign is_sync      = in_data == SYNC;
    assign len_ok       = in_data != 8'h00 && int'(in_data) <= WORD_COUNT;
    assign idx_inc      = idx_q + 1'b1;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_run      = run_q;
    assign cpu_rst      = ~run_q;
    assign load_err     = err_q;
    assign words_loaded = idx_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        xor_d   = xor_q;
        idx_d   = idx_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        run_d   = run_q;
        err_d   = err_q;
        if (acc) begin
            unique case (state_q)
                S_IDLE: state_d = is_sync ? S_LEN : S_IDLE;
                S_LEN: begin
                    state_d = len_ok ? S_HI : S_ERR;
                    err_d   = ~len_ok;
                    if (len_ok) begin
                        xor_d = 8'h00;
                        idx_d = '0;
                        len_d = in_data[ADDR_WIDTH:0];
                    end
                end
                S_HI: begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_LO;
                end
                S_LO: begin
                    xor_d   = xor_q ^ in_data;
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = {hi_q, in_data};
                    idx_d   = idx_inc;
                    state_d = idx_inc == len_q ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    run_d   = in_data == xor_q;
                    err_d   = in_data != xor_q;
                    state_d = in_data == xor_q ? S_RUN : S_ERR;
                end
                // a fresh sync in RUN or ERR starts a reload; the core stays in reset throughout
                S_RUN, S_ERR: begin
                    if (is_sync) begin
                        state_d = S_LEN;
                        run_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= 8'h00;
            xor_q   <= 8'h00;
            idx_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            xor_q   <= xor_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: frame-level reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_imem_boot_loader;
    localparam int WC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, cpu_rst, cpu_run, load_err;
    logic [3:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [4:0]  words_loaded;

    imem_boot_loader #(.ADDR_WIDTH(4), .WORD_COUNT(WC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes since the last sync are buffered and interpreted by position.
    bit          started = 0;
    bit          in_frame = 0;
    logic [7:0]  fq[$];
    int          flen, k;
    logic [7:0]  x;
    logic        m_we = 0, m_run = 0, m_err = 0;
    logic [3:0]  m_addr = 0;
    logic [15:0] m_wdata = 0;
    logic [4:0]  m_words = 0;

    always @(posedge clk) begin
        started = 1;
        m_we = 0;
        if (rst) begin
            in_frame = 0;
            fq.delete();
            m_addr = 0; m_wdata = 0; m_run = 0; m_err = 0; m_words = 0;
        end else if (in_valid) begin
            if (!in_frame) begin
                if (in_data == 8'hA5) begin
                    in_frame = 1; fq.delete(); m_run = 0; m_err = 0;
                end
            end else begin
                fq.push_back(in_data);
                if (fq.size() == 1) begin
                    flen = int'(in_data);
                    if (flen < 1 || flen > WC) begin m_err = 1; in_frame = 0; end
                    else m_words = 0;
                end else if (fq.size() <= 1 + 2 * flen) begin
                    if (fq.size() % 2 == 1) begin
                        k = (fq.size() - 1) / 2;
                        m_we = 1;
                        m_addr = 4'(k - 1);
                        m_wdata = {fq[fq.size()-2], fq[fq.size()-1]};
                        m_words = 5'(k);
                    end
                end else begin
                    x = 0;
                    for (int i = 1; i <= 2 * flen; i++) x ^= fq[i];
                    if (x == in_data) m_run = 1; else m_err = 1;
                    in_frame = 0;
                end
            end
        end
    end

    logic [19:0] wlog[$];

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 32'(in_ready), 32'(!rst));
            chk("imem_we", 32'(imem_we), 32'(m_we));
            chk("imem_addr", 32'(imem_addr), 32'(m_addr));
            chk("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
            chk("cpu_run", 32'(cpu_run), 32'(m_run));
            chk("cpu_rst", 32'(cpu_rst), 32'(!m_run));
            chk("load_err", 32'(load_err), 32'(m_err));
            chk("words_loaded", 32'(words_loaded), 32'(m_words));
            if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});
        end
    end

    logic [7:0]  fb[$];
    logic [19:0] ref_log[$];
    logic [15:0] w;
    logic [7:0]  cs;

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        in_valid = 1; in_data = b;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_fb(input int maxgap);
        foreach (fb[i]) send(fb[i], maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)));
        idle(2);
    endtask

    task automatic reset_pulse();
        rst = 1; idle(2); rst = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        idle(2);
        chk("rst cpu_rst", 32'(cpu_rst), 1);
        chk("rst cpu_run", 32'(cpu_run), 0);
        chk("rst load_err", 32'(load_err), 0);
        chk("rst words", 32'(words_loaded), 0);
        chk("rst addr_data", {12'h0, imem_addr, imem_wdata}, 0);
        chk("rst in_ready", 32'(in_ready), 0);
        rst = 0;

        wlog.delete();
        fb = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_fb(0);
        chk("good nwr", 32'(wlog.size()), 2);
        chk("good wr0", 32'(wlog[0]), 32'h0_1234);
        chk("good wr1", 32'(wlog[1]), 32'h1_ABCD);
        chk("good run", {cpu_run, cpu_rst}, 2'b10);
        chk("good words", 32'(words_loaded), 2);

        wlog.delete();
        fb = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_fb(0);
        chk("bad nwr", 32'(wlog.size()), 2);
        chk("bad err_run", {load_err, cpu_run}, 2'b10);

        reset_pulse();
        wlog.delete();
        fb = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
        send_fb(0);
        chk("garbage nwr", 32'(wlog.size()), 1);
        chk("garbage wr0", 32'(wlog[0]), 32'h0_0007);
        chk("garbage run", 32'(cpu_run), 1);

        wlog.delete();
        fb = '{8'hA5, 8'h00};
        send_fb(0);
        chk("len0 err", {load_err, cpu_run}, 2'b10);
        fb = '{8'hA5, 8'h11};
        send_fb(0);
        chk("len17 err", {load_err, cpu_run}, 2'b10);
        chk("badlen nwr", 32'(wlog.size()), 0);
        fb = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
        send_fb(0);
        chk("recover err_run", {load_err, cpu_run}, 2'b01);

        wlog.delete();
        send(8'hA5, 0);
        chk("reload run drop", 32'(cpu_run), 0);
        fb = '{8'h01, 8'h11, 8'h22, 8'h33};
        send_fb(0);
        chk("reload wr0", 32'(wlog[0]), 32'h0_1122);
        chk("reload run", 32'(cpu_run), 1);

        wlog.delete();
        send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0);
        in_valid = 1; in_data = 8'h34; rst = 1;
        @(posedge clk); #1;
        in_valid = 0;
        idle(1);
        chk("abort nwr", 32'(wlog.size()), 0);
        chk("abort outs", {cpu_run, cpu_rst, load_err, imem_we}, 4'b0100);
        chk("abort addr_data", {12'h0, imem_addr, imem_wdata}, 0);
        chk("abort words", 32'(words_loaded), 0);
        rst = 0;

        fb = '{8'hA5, 8'(WC)};
        cs = 0;
        for (int i = 0; i < WC; i++) begin
            w = (16'h0101 * 16'(i)) ^ 16'hC3A0;
            fb.push_back(w[15:8]); fb.push_back(w[7:0]);
            cs ^= w[15:8] ^ w[7:0];
        end
        fb.push_back(cs);
        wlog.delete();
        send_fb(0);
        ref_log = wlog;
        chk("full nwr", 32'(ref_log.size()), WC);
        chk("full last", 32'(ref_log[WC-1]), 32'hF_CCAF);
        chk("full run", 32'(cpu_run), 1);
        wlog.delete();
        send_fb(5);
        chk("gap nwr", 32'(wlog.size()), WC);
        for (int i = 0; i < WC && i < wlog.size(); i++) chk("gap wr", 32'(wlog[i]), 32'(ref_log[i]));
        chk("gap run", 32'(cpu_run), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
